retire_stage: RTL and testbench

- Commit stage directly downstream of the ROB. Consumes the three in-order retire slots the ROB presents each cycle.
- Writes committed results to the architectural register file.
- Raises the pipeline-wide squash and redirect on a taken branch (front end predicts not-taken).
- Latches program halt.
- All outputs are registered: one-cycle latency from ROB slot to architectural effect.

---
 rtl/sys_defs.sv | 39 +++
 rtl/retire_select.sv | 54 +++++
 rtl/retire_stage.sv | 149 ++++++++++++++
 tb/tb_retire_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared pipeline definitions: ROB retire packet, RF write packet, retire FSM states.
// No logic; types and widths only.
// Consumers must keep RT_WIDTH equal to the ROB retire width.
`ifndef XLEN
`define XLEN 32
`endif

package sys_defs;

   localparam int XLEN       = `XLEN;
   localparam int REG_IDX_W  = 5;
   localparam int RT_WIDTH   = 3;
   localparam int SLOT_IDX_W = $clog2(RT_WIDTH);
   localparam int CNT_W      = 2;

   // One in-order retire slot presented by the ROB
   typedef struct packed {
      logic                 valid;
      logic [REG_IDX_W-1:0] dest_reg_idx;
      logic [XLEN-1:0]      value;
      logic                 take_branch;
      logic [XLEN-1:0]      NPC;
      logic                 halt;
   } ROB_RT_PACKET;

   // One architectural register-file write port
   typedef struct packed {
      logic                 wr_en;
      logic [REG_IDX_W-1:0] wr_idx;
      logic [XLEN-1:0]      wr_data;
   } RT_RF_PACKET;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      SQUASH = 2'd1,
      HALTED = 2'd2
   } RETIRE_STATE;

endpackage

// File: rtl/retire_select.sv
// Slot qualification: commit mask, WAW-masked write enables, branch/halt slot, count.
// Purely combinational, zero latency.
// No backpressure; run=0 blocks every slot from committing.
module retire_select
   import sys_defs::*;
(
   input  logic                        run,
   input  ROB_RT_PACKET [RT_WIDTH-1:0] slots,
   output logic [RT_WIDTH-1:0]         commit_mask,
   output logic [RT_WIDTH-1:0]         wr_mask,
   output logic                        branch_hit,
   output logic                        halt_hit,
   output logic [SLOT_IDX_W-1:0]       term_idx,
   output logic [CNT_W-1:0]            retired_cnt
);

   // Commit is a prefix: stops at the first gap or after the first branch/halt slot
   always_comb begin
      logic cont;
      logic term_found;
      commit_mask = '0;
      branch_hit  = 1'b0;
      halt_hit    = 1'b0;
      term_idx    = '0;
      retired_cnt = '0;
      cont        = run;
      term_found  = 1'b0;
      for (int i = 0; i < RT_WIDTH; i++) begin
         commit_mask[i] = cont & slots[i].valid;
         if (commit_mask[i] && !term_found && (slots[i].take_branch || slots[i].halt)) begin
            term_found = 1'b1;
            term_idx   = SLOT_IDX_W'(i);
            // halt takes priority over a branch in the same slot
            halt_hit   = slots[i].halt;
            branch_hit = slots[i].take_branch & ~slots[i].halt;
         end
         cont        = commit_mask[i] & ~slots[i].take_branch & ~slots[i].halt;
         retired_cnt = retired_cnt + CNT_W'(commit_mask[i]);
      end
   end

   // Drop r0 writes and any write overwritten by a younger committing slot in the group
   always_comb begin
      wr_mask = '0;
      for (int i = 0; i < RT_WIDTH; i++) begin
         wr_mask[i] = commit_mask[i] && (slots[i].dest_reg_idx != '0);
         for (int k = i + 1; k < RT_WIDTH; k++) begin
            if (commit_mask[k] && (slots[k].dest_reg_idx == slots[i].dest_reg_idx))
               wr_mask[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/retire_stage.sv
// Commit stage: RF writes, squash/redirect on taken branch, sticky halt (optional stats: RETIRE_STATS_EN).
// One cycle from ROB slot to registered architectural effect.
// Never stalls the ROB; slots are ignored during SQUASH and HALTED.
module retire_stage
   import sys_defs::*;
#(
   parameter int REG_IDX_W_P = REG_IDX_W,
   parameter int XLEN_P      = XLEN
)
(
   input  logic                                clock,
   input  logic                                reset,
   input  ROB_RT_PACKET [RT_WIDTH-1:0]         RT_packet_in,
   output logic [RT_WIDTH-1:0]                 rf_wr_en,
   output logic [RT_WIDTH-1:0][REG_IDX_W_P-1:0] rf_wr_idx,
   output logic [RT_WIDTH-1:0][XLEN_P-1:0]     rf_wr_data,
   output logic                                squash_flag,
   output logic [XLEN_P-1:0]                   redirect_pc,
   output logic [CNT_W-1:0]                    retired_cnt,
   output logic                                halted
`ifdef RETIRE_STATS_EN
   ,
   output logic [63:0]                         stat_insn_cnt,
   output logic [31:0]                         stat_squash_cnt
`endif
);

   RETIRE_STATE               state_q, state_d;
   RT_RF_PACKET [RT_WIDTH-1:0] rf_q, rf_d;
   logic                      squash_q, squash_d;
   logic [XLEN-1:0]           redirect_q, redirect_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      halted_q, halted_d;

   logic                      run;
   logic [RT_WIDTH-1:0]       commit_mask;
   logic [RT_WIDTH-1:0]       wr_mask;
   logic                      branch_hit;
   logic                      halt_hit;
   logic [SLOT_IDX_W-1:0]     term_idx;
   logic [CNT_W-1:0]          sel_cnt;

   assign run = (state_q == RUN);

   retire_select u_select (
      .run         (run),
      .slots       (RT_packet_in),
      .commit_mask (commit_mask),
      .wr_mask     (wr_mask),
      .branch_hit  (branch_hit),
      .halt_hit    (halt_hit),
      .term_idx    (term_idx),
      .retired_cnt (sel_cnt)
   );

   // Next state and next registered outputs; SQUASH and HALTED commit nothing
   always_comb begin
      state_d    = state_q;
      squash_d   = 1'b0;
      redirect_d = '0;
      cnt_d      = sel_cnt;
      halted_d   = halted_q;
      for (int i = 0; i < RT_WIDTH; i++) begin
         rf_d[i].wr_en   = wr_mask[i];
         rf_d[i].wr_idx  = RT_packet_in[i].dest_reg_idx;
         rf_d[i].wr_data = RT_packet_in[i].value;
      end
      unique case (state_q)
         RUN: begin
            if (halt_hit) begin
               state_d  = HALTED;
               halted_d = 1'b1;
            end else if (branch_hit) begin
               state_d    = SQUASH;
               squash_d   = 1'b1;
               redirect_d = RT_packet_in[term_idx].NPC;
            end
         end
         SQUASH:  state_d = RUN;
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   // State and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= RUN;
         rf_q       <= '0;
         squash_q   <= 1'b0;
         redirect_q <= '0;
         cnt_q      <= '0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rf_q       <= rf_d;
         squash_q   <= squash_d;
         redirect_q <= redirect_d;
         cnt_q      <= cnt_d;
         halted_q   <= halted_d;
      end
   end

   always_comb begin
      for (int i = 0; i < RT_WIDTH; i++) begin
         rf_wr_en[i]   = rf_q[i].wr_en;
         rf_wr_idx[i]  = rf_q[i].wr_idx;
         rf_wr_data[i] = rf_q[i].wr_data;
      end
   end

   assign squash_flag = squash_q;
   assign redirect_pc = redirect_q;
   assign retired_cnt = cnt_q;
   assign halted      = halted_q;

`ifdef RETIRE_STATS_EN
   logic [63:0] insn_q, insn_d;
   logic [31:0] sq_q, sq_d;

   // Saturating counters, advanced with the values being registered this edge
   always_comb begin
      logic [64:0] insn_sum;
      insn_sum = {1'b0, insn_q} + 65'(cnt_d);
      insn_d   = insn_q;
      sq_d     = sq_q;
      if (state_q != HALTED) begin
         insn_d = insn_sum[64] ? '1 : insn_sum[63:0];
         if (squash_d && (sq_q != '1))
            sq_d = sq_q + 32'd1;
      end
   end

   // Statistics registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         insn_q <= '0;
         sq_q   <= '0;
      end else begin
         insn_q <= insn_d;
         sq_q   <= sq_d;
      end
   end

   assign stat_insn_cnt   = insn_q;
   assign stat_squash_cnt = sq_q;
`endif

endmodule

// File: tb/tb_retire_stage.sv
module tb_retire_stage;
   import sys_defs::*;

   logic                            clock;
   logic                            reset;
   ROB_RT_PACKET [RT_WIDTH-1:0]     RT_packet_in;
   logic [RT_WIDTH-1:0]             rf_wr_en;
   logic [RT_WIDTH-1:0][REG_IDX_W-1:0] rf_wr_idx;
   logic [RT_WIDTH-1:0][XLEN-1:0]   rf_wr_data;
   logic                            squash_flag;
   logic [XLEN-1:0]                 redirect_pc;
   logic [CNT_W-1:0]                retired_cnt;
   logic                            halted;

   int checks = 0;
   int errors = 0;

   retire_stage dut (
      .clock        (clock),
      .reset        (reset),
      .RT_packet_in (RT_packet_in),
      .rf_wr_en     (rf_wr_en),
      .rf_wr_idx    (rf_wr_idx),
      .rf_wr_data   (rf_wr_data),
      .squash_flag  (squash_flag),
      .redirect_pc  (redirect_pc),
      .retired_cnt  (retired_cnt),
      .halted       (halted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic ROB_RT_PACKET mk(input logic v, input logic [4:0] d, input logic [31:0] val,
                                       input logic br, input logic [31:0] npc, input logic h);
      ROB_RT_PACKET p;
      p.valid        = v;
      p.dest_reg_idx = d;
      p.value        = XLEN'(val);
      p.take_branch  = br;
      p.NPC          = XLEN'(npc);
      p.halt         = h;
      return p;
   endfunction

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then sample 1 ns later
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set3(input ROB_RT_PACKET s0, input ROB_RT_PACKET s1, input ROB_RT_PACKET s2);
      RT_packet_in[0] = s0;
      RT_packet_in[1] = s1;
      RT_packet_in[2] = s2;
   endtask

   initial begin
      ROB_RT_PACKET nop;
      nop   = mk(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      set3(nop, nop, nop);
      #3;
      chk("reset_wr_en",    96'(rf_wr_en), 96'd0);
      chk("reset_squash",   96'(squash_flag), 96'd0);
      chk("reset_redirect", 96'(redirect_pc), 96'd0);
      chk("reset_cnt",      96'(retired_cnt), 96'd0);
      chk("reset_halted",   96'(halted), 96'd0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;

      // Three plain commits
      set3(mk(1, 1, 5, 0, 0, 0), mk(1, 2, 6, 0, 0, 0), mk(1, 3, 7, 0, 0, 0));
      tick();
      chk("t1_wr_en",  96'(rf_wr_en), 96'b111);
      chk("t1_idx",    96'(rf_wr_idx), 96'({5'd3, 5'd2, 5'd1}));
      chk("t1_data0",  96'(rf_wr_data[0]), 96'd5);
      chk("t1_data1",  96'(rf_wr_data[1]), 96'd6);
      chk("t1_data2",  96'(rf_wr_data[2]), 96'd7);
      chk("t1_cnt",    96'(retired_cnt), 96'd3);
      chk("t1_squash", 96'(squash_flag), 96'd0);

      // Gap in valids truncates commit
      set3(mk(1, 4, 1, 0, 0, 0), mk(0, 5, 2, 0, 0, 0), mk(1, 6, 3, 0, 0, 0));
      tick();
      chk("gap_wr_en", 96'(rf_wr_en), 96'b001);
      chk("gap_cnt",   96'(retired_cnt), 96'd1);

      // Taken branch in slot1: slot2 dropped, squash + redirect
      set3(mk(1, 9, 1, 0, 0, 0), mk(1, 1, 32'h44, 1, 32'h40, 0), mk(1, 2, 2, 0, 0, 0));
      tick();
      chk("br_wr_en",    96'(rf_wr_en), 96'b011);
      chk("br_squash",   96'(squash_flag), 96'd1);
      chk("br_redirect", 96'(redirect_pc), 96'h40);
      chk("br_cnt",      96'(retired_cnt), 96'd2);
      chk("br_link",     96'(rf_wr_data[1]), 96'h44);
      set3(mk(1, 1, 5, 0, 0, 0), mk(1, 2, 6, 0, 0, 0), mk(1, 3, 7, 0, 0, 0));
      tick();
      chk("sq_wr_en",  96'(rf_wr_en), 96'b000);
      chk("sq_squash", 96'(squash_flag), 96'd0);
      chk("sq_cnt",    96'(retired_cnt), 96'd0);
      tick();
      chk("post_sq_wr_en", 96'(rf_wr_en), 96'b111);
      chk("post_sq_cnt",   96'(retired_cnt), 96'd3);

      // Same-group WAW on r3, r0 write suppressed
      set3(mk(1, 3, 9, 0, 0, 0), mk(1, 0, 1, 0, 0, 0), mk(1, 3, 11, 0, 0, 0));
      tick();
      chk("waw_wr_en", 96'(rf_wr_en), 96'b100);
      chk("waw_data2", 96'(rf_wr_data[2]), 96'd11);
      chk("waw_cnt",   96'(retired_cnt), 96'd3);

      // Async reset while squash_flag is high
      set3(mk(1, 4, 1, 1, 32'h80, 0), nop, nop);
      tick();
      chk("ar_squash_pre", 96'(squash_flag), 96'd1);
      chk("ar_halted_pre", 96'(halted), 96'd0);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_squash_drop",   96'(squash_flag), 96'd0);
      chk("ar_redirect_drop", 96'(redirect_pc), 96'd0);
      chk("ar_wr_en_drop",    96'(rf_wr_en), 96'd0);
      @(negedge clock);
      reset = 1'b0;
      set3(mk(1, 1, 5, 0, 0, 0), mk(1, 2, 6, 0, 0, 0), mk(1, 3, 7, 0, 0, 0));
      tick();
      chk("ar_after_wr_en", 96'(rf_wr_en), 96'b111);
      chk("ar_after_cnt",   96'(retired_cnt), 96'd3);

      // Halt in slot0 stops commit, sticky until reset
      set3(mk(1, 0, 0, 0, 0, 1), mk(1, 8, 1, 0, 0, 0), mk(1, 8, 2, 0, 0, 0));
      tick();
      chk("halt_wr_en",  96'(rf_wr_en), 96'b000);
      chk("halt_cnt",    96'(retired_cnt), 96'd1);
      chk("halt_halted", 96'(halted), 96'd1);
      chk("halt_squash", 96'(squash_flag), 96'd0);
      set3(mk(1, 1, 5, 0, 0, 0), mk(1, 2, 6, 0, 0, 0), mk(1, 3, 7, 0, 0, 0));
      tick();
      tick();
      chk("halted_wr_en",  96'(rf_wr_en), 96'b000);
      chk("halted_cnt",    96'(retired_cnt), 96'd0);
      chk("halted_sticky", 96'(halted), 96'd1);

      // Branch and halt in the same slot: halt wins, its write still happens
      reset = 1'b1;
      #1;
      chk("rst_halted_drop", 96'(halted), 96'd0);
      @(negedge clock);
      reset = 1'b0;
      set3(mk(1, 6, 3, 0, 0, 0), mk(1, 5, 4, 1, 32'hC0, 1), mk(1, 7, 5, 0, 0, 0));
      tick();
      chk("bh_wr_en",  96'(rf_wr_en), 96'b011);
      chk("bh_squash", 96'(squash_flag), 96'd0);
      chk("bh_halted", 96'(halted), 96'd1);
      chk("bh_cnt",    96'(retired_cnt), 96'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
